// File: rtl/hit_event_arbiter.sv
// hit_event_arbiter: turns rising edges of debounced button levels into
// one-shot hit requests and serialises them round-robin onto a
// valid/ready event channel.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn_level   debounced button levels, bit i = button i
//   enable      game active; gates capture and new grants
//   hit_valid   registered: event present on hit_id
//   hit_id      registered: index of the pressed button
//   hit_ready   consumer accepts the presented event this cycle
//   pending     captured presses not yet granted
//   overrun     one-cycle pulse: a press merged into a pending one
module hit_event_arbiter #(
    parameter int N_BTN = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_level,
    input  logic             enable,
    output logic             hit_valid,
    output logic [ID_W-1:0]  hit_id,
    input  logic             hit_ready,
    output logic [N_BTN-1:0] pending,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e state_q, state_d;

    logic [N_BTN-1:0]   btn_prev_q;
    logic [N_BTN-1:0]   pending_q, pending_d;
    logic [N_BTN-1:0]   rise;
    logic [N_BTN-1:0]   rot;
    logic [2*N_BTN-1:0] dbl;
    logic [N_BTN-1:0]   grant_mask;
    logic [N_BTN-1:0]   clr_mask;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    hit_id_q, hit_id_d;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic               load;
    logic               overrun_q, overrun_d;

    assign rise = btn_level & ~btn_prev_q;

    // Rotate pending so bit 0 is the rr_ptr position, then take the
    // lowest set bit; its offset from rr_ptr is the grant.
    always_comb begin
        int sum;
        dbl        = {pending_q, pending_q} >> rr_ptr_q;
        rot        = dbl[N_BTN-1:0];
        grant_any  = 1'b0;
        grant_id   = '0;
        grant_mask = '0;
        sum        = 0;
        for (int j = N_BTN - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_any = 1'b1;
                sum = int'(rr_ptr_q) + j;
                if (sum >= N_BTN) begin
                    sum = sum - N_BTN;
                end
                grant_id = ID_W'(sum);
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            grant_mask[i] = grant_any && (int'(grant_id) == i);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && grant_any) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hit_ready && !(enable && grant_any)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Output / load logic
    always_comb begin
        load     = enable && grant_any &&
                   ((state_q == IDLE) || hit_ready);
        hit_id_d = load ? grant_id : hit_id_q;
        clr_mask = load ? grant_mask : '0;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (int'(grant_id) == N_BTN - 1) ?
                       '0 : grant_id + 1'b1;
        end
    end

    // A rise on the bit being granted this cycle re-arms it (set wins),
    // so only bits that stay pending count as a merge.
    always_comb begin
        if (enable) begin
            pending_d = (pending_q & ~clr_mask) | rise;
            overrun_d = |(rise & pending_q & ~clr_mask);
        end else begin
            pending_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            hit_id_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_level;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            hit_id_q   <= hit_id_d;
            overrun_q  <= overrun_d;
        end
    end

    assign hit_valid = (state_q == PRESENT);
    assign hit_id    = hit_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_hit_event_arbiter.sv
// tb_hit_event_arbiter: directed scenarios plus randomized presses,
// checked every cycle against a behavioural model.
module tb_hit_event_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_level = '0;
    logic         enable = 1'b0;
    logic         hit_ready = 1'b0;
    logic         hit_valid;
    logic [W-1:0] hit_id;
    logic [N-1:0] pending;
    logic         overrun;

    int tests = 0;
    int fails = 0;
    int ev_q[$];
    int ov_cnt = 0;

    always #5 clk = ~clk;

    hit_event_arbiter #(.N_BTN(N), .ID_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_level (btn_level),
        .enable    (enable),
        .hit_valid (hit_valid),
        .hit_id    (hit_id),
        .hit_ready (hit_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Behavioural model state
    logic [N-1:0] m_prev, m_pend;
    bit           m_valid, m_ov;
    int           m_id, m_rr;

    // Model next state, from the rules
    logic [N-1:0] n_rise, n_pend;
    int           n_g, n_id, n_rr;
    bit           n_ld, n_valid, n_ov;

    always_comb begin
        n_rise  = btn_level & ~m_prev;
        n_g     = -1;
        for (int k = 0; k < N; k++) begin
            if (n_g < 0 && m_pend[(m_rr + k) % N]) begin
                n_g = (m_rr + k) % N;
            end
        end
        n_ld    = enable && (n_g >= 0) && (!m_valid || hit_ready);
        n_pend  = m_pend;
        n_ov    = 1'b0;
        if (n_ld) begin
            n_pend[n_g] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (enable && n_rise[i]) begin
                if (m_pend[i] && !(n_ld && n_g == i)) begin
                    n_ov = 1'b1;
                end
                n_pend[i] = 1'b1;
            end
        end
        if (!enable) begin
            n_pend = '0;
        end
        n_valid = m_valid;
        n_id    = m_id;
        n_rr    = m_rr;
        if (n_ld) begin
            n_valid = 1'b1;
            n_id    = n_g;
            n_rr    = (n_g + 1) % N;
        end else if (m_valid && hit_ready) begin
            n_valid = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev  <= '0;
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_ov    <= 1'b0;
            m_id    <= 0;
            m_rr    <= 0;
        end else begin
            m_prev  <= btn_level;
            m_pend  <= n_pend;
            m_valid <= n_valid;
            m_ov    <= n_ov;
            m_id    <= n_id;
            m_rr    <= n_rr;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (hit_valid !== m_valid || hit_id !== W'(m_id) ||
                pending !== m_pend || overrun !== m_ov) begin
                fails++;
                $display("FAIL model t=%0t valid %0b/%0b id %0d/%0d pend %b/%b ovr %b/%b",
                         $time, hit_valid, m_valid, hit_id, m_id,
                         pending, m_pend, overrun, m_ov);
            end
            if (hit_valid && hit_ready) begin
                ev_q.push_back(int'(hit_id));
            end
            if (overrun) begin
                ov_cnt++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accepted ids folded into hex digits of (id+1), oldest first
    task automatic chk_ev(input string name, input int exp);
        int sig;
        sig = 0;
        foreach (ev_q[i]) begin
            sig = sig * 16 + ev_q[i] + 1;
        end
        tests++;
        if (sig !== exp) begin
            fails++;
            $display("FAIL %s got events 'h%0h expected 'h%0h", name, sig, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic do_reset();
        btn_level = '0;
        enable    = 1'b0;
        hit_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        tick();
        ev_q.delete();
        ov_cnt = 0;
    endtask

    initial begin
        tick();
        chk("rst_valid", int'(hit_valid), 0);
        chk("rst_id", int'(hit_id), 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_ovr", int'(overrun), 0);

        // Single press
        do_reset();
        enable = 1'b1;
        hit_ready = 1'b1;
        btn_level = 4'b0010;
        tick();
        chk("single_pend_e0", int'(pending), 2);
        chk("single_valid_e0", int'(hit_valid), 0);
        tick();
        chk("single_valid_e1", int'(hit_valid), 1);
        chk("single_id_e1", int'(hit_id), 1);
        tick();
        chk("single_valid_e2", int'(hit_valid), 0);
        btn_level = '0;
        ticks(2);
        chk("single_pend_end", int'(pending), 0);
        chk_ev("single_events", 'h2);

        // Simultaneous presses, then again with rr_ptr wrapping
        do_reset();
        enable = 1'b1;
        hit_ready = 1'b1;
        btn_level = 4'b0101;
        ticks(2);
        chk("simul_id_first", int'(hit_id), 0);
        tick();
        chk("simul_valid_second", int'(hit_valid), 1);
        chk("simul_id_second", int'(hit_id), 2);
        tick();
        btn_level = '0;
        tick();
        btn_level = 4'b0101;
        ticks(4);
        btn_level = '0;
        ticks(2);
        chk_ev("simul_events", 'h1313);

        // Round-robin wrap after granting the top button
        do_reset();
        enable = 1'b1;
        hit_ready = 1'b1;
        btn_level = 4'b1000;
        ticks(3);
        btn_level = '0;
        tick();
        btn_level = 4'b1001;
        ticks(4);
        btn_level = '0;
        tick();
        chk_ev("wrap_events", 'h414);

        // Backpressure and overrun
        do_reset();
        enable = 1'b1;
        btn_level = 4'b0010;
        ticks(2);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) btn_level = 4'b0110;
            if (i == 4) btn_level = 4'b0010;
            if (i == 6) btn_level = 4'b0110;
            tick();
            chk("bp_hold_id", int'(hit_id), 1);
        end
        chk("bp_hold_valid", int'(hit_valid), 1);
        chk("bp_pend", int'(pending), 4);
        hit_ready = 1'b1;
        btn_level = '0;
        ticks(4);
        chk_ev("bp_events", 'h23);
        chk("bp_overruns", ov_cnt, 1);

        // Enable gating
        do_reset();
        enable = 1'b1;
        btn_level = 4'b0010;
        ticks(2);
        btn_level = 4'b0110;
        tick();
        chk("en_pend_before", int'(pending), 4);
        chk("en_id_before", int'(hit_id), 1);
        enable = 1'b0;
        tick();
        chk("en_pend_cleared", int'(pending), 0);
        chk("en_valid_kept", int'(hit_valid), 1);
        btn_level = 4'b1110;
        ticks(2);
        hit_ready = 1'b1;
        ticks(3);
        chk_ev("en_events_disabled", 'h2);
        enable = 1'b1;
        ticks(4);
        chk_ev("en_events_reenable", 'h2);
        chk("en_pend_reenable", int'(pending), 0);

        // Async reset mid-handshake
        do_reset();
        enable = 1'b1;
        btn_level = 4'b0100;
        ticks(2);
        chk("ar_valid_before", int'(hit_valid), 1);
        chk("ar_id_before", int'(hit_id), 2);
        rst_n = 1'b0;
        btn_level = '0;
        #1;
        chk("ar_valid", int'(hit_valid), 0);
        chk("ar_id", int'(hit_id), 0);
        chk("ar_pend", int'(pending), 0);
        chk("ar_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        ev_q.delete();
        hit_ready = 1'b1;
        ticks(4);
        chk("ar_valid_after", int'(hit_valid), 0);
        chk("ar_pend_after", int'(pending), 0);
        chk_ev("ar_events", 0);

        // Randomized stimulus
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) begin
                btn_level[$urandom_range(N - 1)] ^= 1'b1;
            end
            if ($urandom_range(39) == 0) begin
                enable = ~enable;
            end
            hit_ready = ($urandom_range(2) != 0);
            if ($urandom_range(699) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hit_event_arbiter.md
# hit_event_arbiter

Collects the debounced push-button levels of all mole buttons, turns each rising edge into a one-shot hit request, and serialises those requests onto a single valid/ready event channel for the game-scoring logic. Simultaneous presses are not lost. They are queued as per-button pending bits and granted in round-robin order. The block sits between the per-button debounce circuits and the scoring/mole FSM.

## Interface
- N_BTN, 4, number of buttons/moles (2..16)
- ID_W, 2, width of hit_id; must satisfy 2**ID_W >= N_BTN
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- btn_level  in  N_BTN  debounced button levels, bit i = button i
- enable  in  1  game active; gates capture and grant
- hit_valid  out  1  event present on hit_id
- hit_id  out  ID_W  index of the pressed button
- hit_ready  in  1  consumer accepts the event this cycle
- pending  out  N_BTN  captured presses not yet granted (status)
- overrun  out  1  one-cycle pulse: a press was merged into an already-pending one

## Operation
- Reset (async, rst_n=0): btn_prev=0, pending=0, rr_ptr=0, state=IDLE, hit_valid=0, hit_id=0, overrun=0. A reset mid-handshake drops the presented event immediately.
- Edge detect: rise = btn_level & ~btn_prev. btn_prev <= btn_level every cycle, including while enable=0, so that asserting enable creates no spurious edge.
- Capture, when enable=1: for each i with rise[i], pending[i] <= 1.
  - If pending[i] was already 1, pending[i] stays 1 and overrun pulses for one cycle. One pulse covers any number of such bits in a cycle.
  - A rise on the button currently presented on hit_id is a new press. It sets pending normally and is not an overrun.
- Clear on grant: when button k is loaded into the output register, pending[k] <= 0.
  - If the same cycle has rise[k], the set wins: pending[k]=1, no overrun.
- enable=0: rises are ignored and pending <= 0 next cycle. No new grants are made. An event already presented stays valid until accepted.
- Arbitration: the grant index is the first i with pending[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping mod N_BTN. It uses registered pending only. After granting k, rr_ptr <= (k+1) mod N_BTN, so k = N_BTN-1 wraps to 0.
- FSM, two states:
  - IDLE (hit_valid=0): if enable & |pending, load hit_id = grant and go to PRESENT. Otherwise stay.
  - PRESENT (hit_valid=1): if hit_ready=0, hold. If hit_ready=1 and enable & |pending, load the next grant and stay in PRESENT (back-to-back). If hit_ready=1 otherwise, go to IDLE.
- hit_id and hit_valid are registered outputs. While hit_valid=1 and hit_ready=0 they must not change. hit_id holds its last value in IDLE.

## Timing
- Latency:
  - btn_level first sampled high at edge E0: pending[i]=1 after E0.
  - hit_valid=1, hit_id=i after E1.
  - Accepted at the first edge where hit_ready=1.
- Throughput: one event per cycle while pending is nonzero and hit_ready=1.
- overrun is asserted in the cycle after the offending rise is sampled, for exactly one cycle.
- pending reflects the register state. A bit shows 1 from the edge after capture until the edge that grants it.
- Deasserting enable at edge E clears pending after E+1. A presented event persists.
- No combinational path from any input to any output.

## Test plan
- Single press: N_BTN=4, enable=1, btn_level=0010 held 3 cycles. hit_valid rises 2 edges after the first high sample with hit_id=1. With hit_ready=1, exactly one event is seen and pending returns to 0000.
- Simultaneous presses, rr_ptr=0: btn_level 0000→0101, hit_ready=1. Events are id 0 then id 2 on consecutive cycles. A following simultaneous 0101 press then grants id 0 first again (rr_ptr=3 wraps to 0).
- Round-robin wrap: press 3, accept, then press 3 and 0 together. Order is 0 then 3 (rr_ptr=0 after granting 3).
- Backpressure and overrun: press 1, hold hit_ready=0 for 10 cycles. hit_id=1 stays stable. Press 2 twice during the hold: first press sets pending[2], second pulses overrun once. Release ready: events are 1 then 2 only.
- Enable gating: pending=0100 with hit_valid=1 (id 1, ready low), then enable→0. pending clears next cycle. Event id 1 is still delivered on ready. A press made while disabled produces no event. Re-enabling with a button held produces no event.
- Async reset mid-handshake: hit_valid=1 and rst_n pulsed low between edges. All outputs go to 0 without waiting for a clock edge. After release, no stale event or pending bit remains.
